// File: rtl/snow64_mem_access_arbiter_if.sv
// ============================================================================
// Module      : snow64_mem_access_arbiter_if
// Description : Bundle of icache, dcache and memory-port signals for the
//               shared memory-access arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface snow64_mem_access_arbiter_if #(
  parameter int WIDTH__ADDR      = 64,
  parameter int WIDTH__LINE_DATA = 256
);
  logic                        in_icache_req;
  logic [WIDTH__ADDR-1:0]      in_icache_addr;
  logic                        out_icache_valid;
  logic [WIDTH__LINE_DATA-1:0] out_icache_data;

  logic                        in_dcache_req;
  logic                        in_dcache_write;
  logic [WIDTH__ADDR-1:0]      in_dcache_addr;
  logic [WIDTH__LINE_DATA-1:0] in_dcache_data;
  logic                        out_dcache_valid;
  logic [WIDTH__LINE_DATA-1:0] out_dcache_data;

  logic                        out_mem_req;
  logic                        out_mem_write;
  logic [WIDTH__ADDR-1:0]      out_mem_addr;
  logic [WIDTH__LINE_DATA-1:0] out_mem_data;
  logic                        in_mem_valid;
  logic [WIDTH__LINE_DATA-1:0] in_mem_data;

  logic                        out_busy;

  // Arbiter side
  modport slave (
    input  in_icache_req, in_icache_addr,
    input  in_dcache_req, in_dcache_write, in_dcache_addr, in_dcache_data,
    input  in_mem_valid, in_mem_data,
    output out_icache_valid, out_icache_data,
    output out_dcache_valid, out_dcache_data,
    output out_mem_req, out_mem_write, out_mem_addr, out_mem_data,
    output out_busy
  );

  // Caches/memory side
  modport master (
    output in_icache_req, in_icache_addr,
    output in_dcache_req, in_dcache_write, in_dcache_addr, in_dcache_data,
    output in_mem_valid, in_mem_data,
    input  out_icache_valid, out_icache_data,
    input  out_dcache_valid, out_dcache_data,
    input  out_mem_req, out_mem_write, out_mem_addr, out_mem_data,
    input  out_busy
  );
endinterface

`default_nettype wire

// File: rtl/snow64_mem_access_arbiter.sv
// ============================================================================
// Module      : snow64_mem_access_arbiter
// Description : Arbitrates the single memory port between icache line reads
//               and dcache reads/writebacks. Tie policy selected by the
//               SNOW64_MEM_ARB_ROUND_ROBIN_EN macro (default: dcache wins).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module snow64_mem_access_arbiter #(
  parameter int WIDTH__ADDR      = 64,
  parameter int WIDTH__LINE_DATA = 256
) (
  input  wire logic                       clk,
  input  wire logic                       rst,
  snow64_mem_access_arbiter_if.slave      bus
);

  typedef enum logic [0:0] {
    StIdle       = 1'b0,
    StWaitForMem = 1'b1
  } state_t;

  localparam logic c_client_icache = 1'b0;
  localparam logic c_client_dcache = 1'b1;

  state_t                      state_q, state_d;
  logic                        owner_q, owner_d;

  logic                        ic_pend_q, ic_pend_d;
  logic [WIDTH__ADDR-1:0]      ic_addr_q, ic_addr_d;
  logic                        dc_pend_q, dc_pend_d;
  logic                        dc_write_q, dc_write_d;
  logic [WIDTH__ADDR-1:0]      dc_addr_q, dc_addr_d;
  logic [WIDTH__LINE_DATA-1:0] dc_data_q, dc_data_d;

  logic                        mem_req_q, mem_req_d;
  logic                        mem_write_q, mem_write_d;
  logic [WIDTH__ADDR-1:0]      mem_addr_q, mem_addr_d;
  logic [WIDTH__LINE_DATA-1:0] mem_data_q, mem_data_d;
  logic                        icache_valid_q, icache_valid_d;
  logic [WIDTH__LINE_DATA-1:0] icache_data_q, icache_data_d;
  logic                        dcache_valid_q, dcache_valid_d;
  logic [WIDTH__LINE_DATA-1:0] dcache_data_q, dcache_data_d;
  logic                        busy_q, busy_d;

  logic                        w_ic_accept, w_dc_accept;
  logic                        w_ic_cand, w_dc_cand;
  logic                        w_tie_pick_dc, w_grant_dc;

`ifdef SNOW64_MEM_ARB_ROUND_ROBIN_EN
  // Holds the client granted most recently; the other one wins the next tie
  logic                        rr_last_q, rr_last_d;
  assign w_tie_pick_dc = (rr_last_q == c_client_icache);
`else
  assign w_tie_pick_dc = 1'b1;
`endif

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    ic_pend_d      = ic_pend_q;
    ic_addr_d      = ic_addr_q;
    dc_pend_d      = dc_pend_q;
    dc_write_d     = dc_write_q;
    dc_addr_d      = dc_addr_q;
    dc_data_d      = dc_data_q;
    mem_req_d      = 1'b0;
    mem_write_d    = mem_write_q;
    mem_addr_d     = mem_addr_q;
    mem_data_d     = mem_data_q;
    icache_valid_d = 1'b0;
    icache_data_d  = icache_data_q;
    dcache_valid_d = 1'b0;
    dcache_data_d  = dcache_data_q;
`ifdef SNOW64_MEM_ARB_ROUND_ROBIN_EN
    rr_last_d      = rr_last_q;
`endif

    // Drop a request from a client that is already queued or being served
    w_ic_accept = bus.in_icache_req & ~ic_pend_q &
                  ~((state_q == StWaitForMem) && (owner_q == c_client_icache));
    w_dc_accept = bus.in_dcache_req & ~dc_pend_q &
                  ~((state_q == StWaitForMem) && (owner_q == c_client_dcache));

    if (w_ic_accept) begin
      ic_pend_d = 1'b1;
      ic_addr_d = bus.in_icache_addr;
    end
    if (w_dc_accept) begin
      dc_pend_d  = 1'b1;
      dc_write_d = bus.in_dcache_write;
      dc_addr_d  = bus.in_dcache_addr;
      dc_data_d  = bus.in_dcache_data;
    end

    w_ic_cand  = ic_pend_d;
    w_dc_cand  = dc_pend_d;
    w_grant_dc = w_dc_cand & (~w_ic_cand | w_tie_pick_dc);

    case (state_q)
      StIdle: begin
        if (w_ic_cand | w_dc_cand) begin
          mem_req_d = 1'b1;
          state_d   = StWaitForMem;
          if (w_grant_dc) begin
            dc_pend_d   = 1'b0;
            owner_d     = c_client_dcache;
            mem_write_d = dc_write_d;
            mem_addr_d  = dc_addr_d;
            mem_data_d  = dc_data_d;
          end else begin
            ic_pend_d   = 1'b0;
            owner_d     = c_client_icache;
            mem_write_d = 1'b0;
            mem_addr_d  = ic_addr_d;
            mem_data_d  = '0;
          end
`ifdef SNOW64_MEM_ARB_ROUND_ROBIN_EN
          rr_last_d = w_grant_dc ? c_client_dcache : c_client_icache;
`endif
        end
      end
      StWaitForMem: begin
        if (bus.in_mem_valid) begin
          state_d = StIdle;
          if (owner_q == c_client_dcache) begin
            dcache_valid_d = 1'b1;
            if (!mem_write_q) dcache_data_d = bus.in_mem_data;
          end else begin
            icache_valid_d = 1'b1;
            icache_data_d  = bus.in_mem_data;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d == StWaitForMem);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      owner_q        <= c_client_icache;
      ic_pend_q      <= 1'b0;
      ic_addr_q      <= '0;
      dc_pend_q      <= 1'b0;
      dc_write_q     <= 1'b0;
      dc_addr_q      <= '0;
      dc_data_q      <= '0;
      mem_req_q      <= 1'b0;
      mem_write_q    <= 1'b0;
      mem_addr_q     <= '0;
      mem_data_q     <= '0;
      icache_valid_q <= 1'b0;
      icache_data_q  <= '0;
      dcache_valid_q <= 1'b0;
      dcache_data_q  <= '0;
      busy_q         <= 1'b0;
`ifdef SNOW64_MEM_ARB_ROUND_ROBIN_EN
      rr_last_q      <= c_client_icache;
`endif
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      ic_pend_q      <= ic_pend_d;
      ic_addr_q      <= ic_addr_d;
      dc_pend_q      <= dc_pend_d;
      dc_write_q     <= dc_write_d;
      dc_addr_q      <= dc_addr_d;
      dc_data_q      <= dc_data_d;
      mem_req_q      <= mem_req_d;
      mem_write_q    <= mem_write_d;
      mem_addr_q     <= mem_addr_d;
      mem_data_q     <= mem_data_d;
      icache_valid_q <= icache_valid_d;
      icache_data_q  <= icache_data_d;
      dcache_valid_q <= dcache_valid_d;
      dcache_data_q  <= dcache_data_d;
      busy_q         <= busy_d;
`ifdef SNOW64_MEM_ARB_ROUND_ROBIN_EN
      rr_last_q      <= rr_last_d;
`endif
    end
  end

  assign bus.out_mem_req      = mem_req_q;
  assign bus.out_mem_write    = mem_write_q;
  assign bus.out_mem_addr     = mem_addr_q;
  assign bus.out_mem_data     = mem_data_q;
  assign bus.out_icache_valid = icache_valid_q;
  assign bus.out_icache_data  = icache_data_q;
  assign bus.out_dcache_valid = dcache_valid_q;
  assign bus.out_dcache_data  = dcache_data_q;
  assign bus.out_busy         = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_snow64_mem_access_arbiter.sv
// ============================================================================
// Module      : tb_snow64_mem_access_arbiter
// Description : Table-driven bench for the memory-access arbiter plus short
//               hand-written idle-valid and reset-while-busy sequences.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_snow64_mem_access_arbiter;

`ifdef SNOW64_MEM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef logic [63:0]  addr_t;
  typedef logic [255:0] line_t;

  typedef struct {
    logic  rst;
    logic  icr;  addr_t ica;
    logic  dcr;  logic dcw; addr_t dca; line_t dcd;
    logic  mv;   line_t md;
    logic  emr;  logic emw; addr_t ema; line_t emd;
    logic  eiv;  line_t eid;
    logic  edv;  line_t edd;
    logic  eb;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  vec_t vq[$];

  always #5 clk = ~clk;

  snow64_mem_access_arbiter_if bus ();

  snow64_mem_access_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic line_t fill(input logic [7:0] b);
    return {32{b}};
  endfunction

  task automatic chk(input string name, input int row, input line_t act, input line_t exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s row %0d: got %h want %h", name, row, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic icr, input addr_t ica,
                     input logic dcr, input logic dcw, input addr_t dca, input line_t dcd,
                     input logic mv, input line_t md,
                     input logic emr, input logic emw, input addr_t ema, input line_t emd,
                     input logic eiv, input line_t eid, input logic edv, input line_t edd,
                     input logic eb);
    vec_t v;
    v.rst = r; v.icr = icr; v.ica = ica; v.dcr = dcr; v.dcw = dcw; v.dca = dca;
    v.dcd = dcd; v.mv = mv; v.md = md; v.emr = emr; v.emw = emw; v.ema = ema;
    v.emd = emd; v.eiv = eiv; v.eid = eid; v.edv = edv; v.edd = edd; v.eb = eb;
    vq.push_back(v);
  endtask

  task automatic drive(input logic r, input logic icr, input addr_t ica,
                       input logic dcr, input logic dcw, input addr_t dca, input line_t dcd,
                       input logic mv, input line_t md);
    rst                 = r;
    bus.in_icache_req   = icr;
    bus.in_icache_addr  = ica;
    bus.in_dcache_req   = dcr;
    bus.in_dcache_write = dcw;
    bus.in_dcache_addr  = dca;
    bus.in_dcache_data  = dcd;
    bus.in_mem_valid    = mv;
    bus.in_mem_data     = md;
  endtask

  // One cycle of idle inputs, then sample just after the edge
  task automatic idle_cycle();
    @(negedge clk);
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    line_t z;
    z = '0;
    drive(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_req",   -1, line_t'(bus.out_mem_req), 0);
    chk("rst_mem_write", -1, line_t'(bus.out_mem_write), 0);
    chk("rst_mem_addr",  -1, line_t'(bus.out_mem_addr), 0);
    chk("rst_mem_data",  -1, bus.out_mem_data, 0);
    chk("rst_ic_valid",  -1, line_t'(bus.out_icache_valid), 0);
    chk("rst_ic_data",   -1, bus.out_icache_data, 0);
    chk("rst_dc_valid",  -1, line_t'(bus.out_dcache_valid), 0);
    chk("rst_dc_data",   -1, bus.out_dcache_data, 0);
    chk("rst_busy",      -1, line_t'(bus.out_busy), 0);

    //   rst icr ica     dcr dcw dca     dcd         mv md          emr emw ema     emd         eiv eid         edv edd         eb
    // single icache read
    add(0, 1, 'h40,  0, 0, 0,      z,          0, z,          1, 0, 'h40,  z,          0, z,          0, z,          1);
    add(0, 0, 0,     0, 0, 0,      z,          0, z,          0, 0, 0,     z,          0, z,          0, z,          1);
    add(0, 0, 0,     0, 0, 0,      z,          1, fill(8'hAA),0, 0, 0,     z,          1, fill(8'hAA),0, z,          0);
    add(0, 0, 0,     0, 0, 0,      z,          0, z,          0, 0, 0,     z,          0, z,          0, z,          0);
    // dcache writeback; ack leaves dcache data untouched
    add(0, 0, 0,     1, 1, 'h80,   'h1234,     0, z,          1, 1, 'h80,  'h1234,     0, z,          0, z,          1);
    add(0, 0, 0,     0, 0, 0,      z,          1, fill(8'h55),0, 0, 0,     z,          0, z,          1, z,          0);
    add(0, 0, 0,     0, 0, 0,      z,          0, z,          0, 0, 0,     z,          0, z,          0, z,          0);
    // reset, then same-cycle tie: dcache first, icache at M+2
    add(1, 0, 0,     0, 0, 0,      z,          0, z,          0, 0, 0,     z,          0, z,          0, z,          0);
    add(0, 1, 'h100, 1, 0, 'h200,  z,          0, z,          1, 0, 'h200, z,          0, z,          0, z,          1);
    add(0, 0, 0,     0, 0, 0,      z,          1, fill(8'hBB),0, 0, 0,     z,          0, z,          1, fill(8'hBB),0);
    add(0, 0, 0,     0, 0, 0,      z,          0, z,          1, 0, 'h100, z,          0, z,          0, z,          1);
    add(0, 0, 0,     0, 0, 0,      z,          1, fill(8'hCC),0, 0, 0,     z,          1, fill(8'hCC),0, z,          0);
    // tie after an icache grant
    add(0, 1, 'h140, 1, 0, 'h240,  z,          0, z,          1, 0, 'h240, z,          0, z,          0, z,          1);
    add(0, 0, 0,     0, 0, 0,      z,          1, fill(8'hDD),0, 0, 0,     z,          0, z,          1, fill(8'hDD),0);
    add(0, 0, 0,     0, 0, 0,      z,          0, z,          1, 0, 'h140, z,          0, z,          0, z,          1);
    add(0, 0, 0,     0, 0, 0,      z,          1, fill(8'hEE),0, 0, 0,     z,          1, fill(8'hEE),0, z,          0);
    // lone dcache read, then a tie: round-robin now favours icache
    add(0, 0, 0,     1, 0, 'h300,  z,          0, z,          1, 0, 'h300, z,          0, z,          0, z,          1);
    add(0, 0, 0,     0, 0, 0,      z,          1, fill(8'h11),0, 0, 0,     z,          0, z,          1, fill(8'h11),0);
    add(0, 1, 'h180, 1, 0, 'h380,  z,          0, z,          1, 0, RR ? 'h180 : 'h380, z, 0, z,       0, z,          1);
    add(0, 0, 0,     0, 0, 0,      z,          1, fill(8'h22),0, 0, 0,     z,          RR, fill(8'h22), !RR, fill(8'h22), 0);
    add(0, 0, 0,     0, 0, 0,      z,          0, z,          1, 0, RR ? 'h380 : 'h180, z, 0, z,       0, z,          1);
    add(0, 0, 0,     0, 0, 0,      z,          1, fill(8'h33),0, 0, 0,     z,          !RR, fill(8'h33), RR, fill(8'h33), 0);
    // icache request queued behind an in-flight dcache writeback
    add(0, 0, 0,     1, 1, 'h400,  'h77,       0, z,          1, 1, 'h400, 'h77,       0, z,          0, z,          1);
    add(0, 1, 'h440, 0, 0, 0,      z,          0, z,          0, 0, 0,     z,          0, z,          0, z,          1);
    add(0, 0, 0,     0, 0, 0,      z,          1, fill(8'h99),0, 0, 0,     z,          0, z,          1, RR ? fill(8'h33) : fill(8'h22), 0);
    add(0, 0, 0,     0, 0, 0,      z,          0, z,          1, 0, 'h440, z,          0, z,          0, z,          1);
    add(0, 0, 0,     0, 0, 0,      z,          1, fill(8'h44),0, 0, 0,     z,          1, fill(8'h44),0, z,          0);
    // second icache request while the first is pending is dropped
    add(0, 0, 0,     1, 0, 'h500,  z,          0, z,          1, 0, 'h500, z,          0, z,          0, z,          1);
    add(0, 1, 'h540, 0, 0, 0,      z,          0, z,          0, 0, 0,     z,          0, z,          0, z,          1);
    add(0, 1, 'h580, 0, 0, 0,      z,          0, z,          0, 0, 0,     z,          0, z,          0, z,          1);
    add(0, 0, 0,     0, 0, 0,      z,          1, fill(8'h55),0, 0, 0,     z,          0, z,          1, fill(8'h55),0);
    add(0, 0, 0,     0, 0, 0,      z,          0, z,          1, 0, 'h540, z,          0, z,          0, z,          1);
    add(0, 0, 0,     0, 0, 0,      z,          1, fill(8'h66),0, 0, 0,     z,          1, fill(8'h66),0, z,          0);
    add(0, 0, 0,     0, 0, 0,      z,          0, z,          0, 0, 0,     z,          0, z,          0, z,          0);
    add(0, 0, 0,     0, 0, 0,      z,          0, z,          0, 0, 0,     z,          0, z,          0, z,          0);

    foreach (vq[i]) begin
      @(negedge clk);
      drive(vq[i].rst, vq[i].icr, vq[i].ica, vq[i].dcr, vq[i].dcw, vq[i].dca, vq[i].dcd,
            vq[i].mv, vq[i].md);
      @(posedge clk);
      #1;
      chk("mem_req",  i, line_t'(bus.out_mem_req), line_t'(vq[i].emr));
      chk("ic_valid", i, line_t'(bus.out_icache_valid), line_t'(vq[i].eiv));
      chk("dc_valid", i, line_t'(bus.out_dcache_valid), line_t'(vq[i].edv));
      chk("busy",     i, line_t'(bus.out_busy), line_t'(vq[i].eb));
      if (vq[i].emr) begin
        chk("mem_write", i, line_t'(bus.out_mem_write), line_t'(vq[i].emw));
        chk("mem_addr",  i, line_t'(bus.out_mem_addr), line_t'(vq[i].ema));
        if (vq[i].emw) chk("mem_data", i, bus.out_mem_data, vq[i].emd);
      end
      if (vq[i].eiv) chk("ic_data", i, bus.out_icache_data, vq[i].eid);
      if (vq[i].edv) chk("dc_data", i, bus.out_dcache_data, vq[i].edd);
    end

    // in_mem_valid while idle produces nothing
    @(negedge clk);
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b1, fill(8'hF0));
    @(posedge clk);
    #1;
    chk("idle_mv_ic_valid", 100, line_t'(bus.out_icache_valid), 0);
    chk("idle_mv_dc_valid", 100, line_t'(bus.out_dcache_valid), 0);
    chk("idle_mv_busy",     100, line_t'(bus.out_busy), 0);
    idle_cycle();
    chk("idle_mv_ic_data",  101, bus.out_icache_data, fill(8'h66));

    // reset while busy with icache still pending
    @(negedge clk);
    drive(1'b0, 1'b1, 'h600, 1'b1, 1'b0, 'h700, '0, 1'b0, '0);
    @(posedge clk);
    #1;
    chk("rb_mem_req", 102, line_t'(bus.out_mem_req), 1);
    chk("rb_busy",    102, line_t'(bus.out_busy), 1);
    @(negedge clk);
    drive(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
    @(posedge clk);
    #1;
    chk("rb_busy_after_rst", 103, line_t'(bus.out_busy), 0);
    for (int k = 0; k < 3; k++) begin
      idle_cycle();
      chk("rb_no_pending_grant", 104 + k, line_t'(bus.out_mem_req), 0);
    end
    @(negedge clk);
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b1, fill(8'h0F));
    @(posedge clk);
    #1;
    chk("rb_late_ic_valid", 107, line_t'(bus.out_icache_valid), 0);
    chk("rb_late_dc_valid", 107, line_t'(bus.out_dcache_valid), 0);

    // arbiter still serves requests afterwards
    @(negedge clk);
    drive(1'b0, 1'b1, 'h800, 1'b0, 1'b0, '0, '0, 1'b0, '0);
    @(posedge clk);
    #1;
    chk("post_mem_req",  108, line_t'(bus.out_mem_req), 1);
    chk("post_mem_addr", 108, line_t'(bus.out_mem_addr), 'h800);
    idle_cycle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
